nand_sync_counter: RTL and testbench



---
 rtl/nand_sync_counter.sv | 85 ++++++++
 tb/tb_nand_sync_counter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/nand_sync_counter.sv
// Up/down binary counter whose next-state and terminal-count logic is built
// entirely from Nand2 cells; only the state register is behavioural.

module Nand2 (
   input  logic in1,
   input  logic in2,
   output logic out
);

   assign out = ~(in1 & in2);

endmodule

module nand_sync_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             tc
);

   logic [WIDTH-1:0] r_q;

   logic             w_up_n;
   logic             w_load_n;
   logic [WIDTH:0]   w_t;
   logic [WIDTH-1:0] w_q_n;
   logic [WIDTH-1:0] w_sel_a;
   logic [WIDTH-1:0] w_sel_b;
   logic [WIDTH-1:0] w_m;
   logic [WIDTH-1:0] w_t_nand;
   logic [WIDTH-1:0] w_x1;
   logic [WIDTH-1:0] w_x2;
   logic [WIDTH-1:0] w_x3;
   logic [WIDTH-1:0] w_x;
   logic [WIDTH-1:0] w_ld_a;
   logic [WIDTH-1:0] w_ld_b;
   logic [WIDTH-1:0] w_nxt;

   // Select inverters shared by every bit's direction mux and load mux.
   Nand2 u_up_inv   (.in1(up_dn), .in2(up_dn), .out(w_up_n));
   Nand2 u_load_inv (.in1(load),  .in2(load),  .out(w_load_n));

   assign w_t[0] = en;

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         // m = up_dn ? q : ~q decides whether this bit propagates the carry/borrow.
         Nand2 u_q_inv  (.in1(r_q[i]),      .in2(r_q[i]),      .out(w_q_n[i]));
         Nand2 u_sel_a  (.in1(up_dn),       .in2(r_q[i]),      .out(w_sel_a[i]));
         Nand2 u_sel_b  (.in1(w_up_n),      .in2(w_q_n[i]),    .out(w_sel_b[i]));
         Nand2 u_sel_o  (.in1(w_sel_a[i]),  .in2(w_sel_b[i]),  .out(w_m[i]));

         Nand2 u_t_nand (.in1(w_t[i]),      .in2(w_m[i]),      .out(w_t_nand[i]));
         Nand2 u_t_inv  (.in1(w_t_nand[i]), .in2(w_t_nand[i]), .out(w_t[i+1]));

         Nand2 u_x1     (.in1(r_q[i]),      .in2(w_t[i]),      .out(w_x1[i]));
         Nand2 u_x2     (.in1(r_q[i]),      .in2(w_x1[i]),     .out(w_x2[i]));
         Nand2 u_x3     (.in1(w_t[i]),      .in2(w_x1[i]),     .out(w_x3[i]));
         Nand2 u_x4     (.in1(w_x2[i]),     .in2(w_x3[i]),     .out(w_x[i]));

         // Load overrides the toggled value regardless of en and up_dn.
         Nand2 u_ld_a   (.in1(load),        .in2(d[i]),        .out(w_ld_a[i]));
         Nand2 u_ld_b   (.in1(w_load_n),    .in2(w_x[i]),      .out(w_ld_b[i]));
         Nand2 u_ld_o   (.in1(w_ld_a[i]),   .in2(w_ld_b[i]),   .out(w_nxt[i]));
      end
   endgenerate

   assign tc = w_t[WIDTH];
   assign q  = r_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= {WIDTH{1'b0}};
      end else begin
         r_q <= w_nxt;
      end
   end

endmodule

// File: tb/tb_nand_sync_counter.sv
// Directed bench for nand_sync_counter: a modulo-arithmetic reference model
// checked every cycle, plus hand-computed expectations and an 8-bit cascade.

module tb_nand_sync_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       up_dn = 1'b1;
   logic       load = 1'b0;
   logic [3:0] d = 4'd0;
   logic [3:0] q;
   logic       tc;

   logic       en_c = 1'b0;
   logic [3:0] q_lo;
   logic [3:0] q_hi;
   logic       tc_lo;
   logic       tc_hi;

   int errors = 0;
   int checks = 0;
   bit chk_on = 1'b0;

   int m_q = 0;
   int m_c = 0;

   always #5 clk = ~clk;

   nand_sync_counter #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .d(d), .q(q), .tc(tc)
   );

   nand_sync_counter #(.WIDTH(4)) u_lo (
      .clk(clk), .rst(rst), .en(en_c), .up_dn(1'b1), .load(1'b0), .d(4'd0), .q(q_lo), .tc(tc_lo)
   );

   nand_sync_counter #(.WIDTH(4)) u_hi (
      .clk(clk), .rst(rst), .en(tc_lo), .up_dn(1'b1), .load(1'b0), .d(4'd0), .q(q_hi), .tc(tc_hi)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Reference model: plain modulo arithmetic on integers.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_q <= 0;
         m_c <= 0;
      end else begin
         if (load)
            m_q <= int'(d);
         else if (en)
            m_q <= up_dn ? (m_q + 1) % 16 : (m_q + 15) % 16;
         if (en_c)
            m_c <= (m_c + 1) % 256;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("model_q",  int'(q), m_q);
         chk("model_tc", int'(tc), int'(en && (up_dn ? (m_q == 15) : (m_q == 0))));
         chk("casc_q",   int'({q_hi, q_lo}), m_c);
         chk("casc_tclo", int'(tc_lo), int'(en_c && (m_c % 16 == 15)));
         chk("casc_tchi", int'(tc_hi), int'(en_c && (m_c == 255)));
      end
   end

   initial begin
      repeat (2) tick();
      chk("reset_q", int'(q), 0);
      chk("reset_tc", int'(tc), 0);
      rst = 1'b0;
      chk_on = 1'b1;

      // Reset mid-count from q=9, asynchronously between edges.
      load = 1'b1; d = 4'd9;
      tick();
      load = 1'b0;
      chk("load9", int'(q), 9);
      #1 rst = 1'b1;
      #1 chk("async_rst", int'(q), 0);
      repeat (3) tick();
      chk("rst_hold", int'(q), 0);
      rst = 1'b0; en = 1'b1; up_dn = 1'b1;
      tick();
      chk("post_rst_count", int'(q), 1);

      // Up count from 0 through wrap.
      load = 1'b1; d = 4'd0;
      tick();
      load = 1'b0;
      chk("load0", int'(q), 0);
      for (int i = 1; i <= 17; i++) begin
         tick();
         chk("up_q", int'(q), i % 16);
         chk("up_tc", int'(tc), int'(i % 16 == 15));
      end
      chk("up_wrap_lit", int'(q), 1);

      // Down count through wrap.
      load = 1'b1; d = 4'd2;
      tick();
      load = 1'b0; up_dn = 1'b0;
      chk("load2", int'(q), 2);
      tick(); chk("dn1", int'(q), 1);  chk("dn1_tc", int'(tc), 0);
      tick(); chk("dn0", int'(q), 0);  chk("dn0_tc", int'(tc), 1);
      tick(); chk("dn15", int'(q), 15); chk("dn15_tc", int'(tc), 0);
      tick(); chk("dn14", int'(q), 14);

      // Load wins over count enable.
      load = 1'b1; d = 4'd7; up_dn = 1'b1;
      tick();
      chk("load7", int'(q), 7);
      d = 4'd12;
      tick();
      chk("load_prio", int'(q), 12);
      load = 1'b0;
      tick();
      chk("after_load", int'(q), 13);

      // Hold at 15 with en low, then enable.
      load = 1'b1; d = 4'd15;
      tick();
      load = 1'b0; en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold_q", int'(q), 15);
         chk("hold_tc", int'(tc), 0);
      end
      up_dn = 1'b0;
      #1 chk("hold_dn_tc", int'(tc), 0);
      up_dn = 1'b1;
      en = 1'b1;
      #1 chk("en_tc", int'(tc), 1);
      tick();
      chk("hold_wrap", int'(q), 0);
      en = 1'b0;

      // 8-bit cascade of two stages.
      en_c = 1'b1;
      repeat (255) tick();
      chk("casc_ff", int'({q_hi, q_lo}), 255);
      chk("casc_tclo_lit", int'(tc_lo), 1);
      chk("casc_tchi_lit", int'(tc_hi), 1);
      tick();
      chk("casc_00", int'({q_hi, q_lo}), 0);
      en_c = 1'b0;
      tick();

      chk_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
